ram_multiport_arb: RTL and testbench

//   Parametrised shared RAM: num_ports independent requesters access one

---
 rtl/ram_multiport_arb.sv | 111 +++++++++++
 tb/tb_ram_multiport_arb.sv | 209 ++++++++++++++++++++
 2 files changed

// File: rtl/ram_multiport_arb.sv
// Shared single-port RAM behind a round-robin arbiter: one access per clock,
// registered read data with a one-cycle valid pulse per requesting port.
module ram_multiport_arb #(
    parameter int addr_size   = 10,
    parameter int word_size   = 8,
    parameter int memory_size = 1024,
    parameter int num_ports   = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic [num_ports-1:0]           req,
    input  logic [num_ports-1:0]           wr,
    input  logic [num_ports*addr_size-1:0] addr,
    input  logic [num_ports*word_size-1:0] data_in,
    output logic [num_ports-1:0]           gnt,
    output logic [num_ports-1:0]           rd_valid,
    output logic [num_ports*word_size-1:0] data_out
);

    localparam int PW = $clog2(num_ports);
    localparam int MW = (memory_size > 1) ? $clog2(memory_size) : 1;
    localparam logic [addr_size:0] MEM_LIM = (addr_size+1)'(memory_size);

    logic [PW-1:0]              r_ptr;
    logic [num_ports-1:0]       r_rd_valid;
    logic [num_ports*word_size-1:0] r_data_out;
    logic [word_size-1:0]       r_mem [memory_size];

    logic [PW-1:0]              w_sel;
    logic [PW-1:0]              w_ptr_nxt;
    logic                       w_found;
    logic                       w_go;
    logic [addr_size-1:0]       w_addr_sel;
    logic                       w_wr_sel;
    logic [word_size-1:0]       w_din_sel;
    logic [word_size-1:0]       w_rd_word;
    logic                       w_in_range;
    logic [MW-1:0]              w_mem_idx;

    // Scan ports starting at r_ptr, wrapping modulo num_ports; first requester wins.
    always_comb begin : p_arb
        logic [PW:0]   sum;
        logic [PW-1:0] idx;
        w_found = 1'b0;
        w_sel   = '0;
        sum     = '0;
        idx     = '0;
        for (int i = 0; i < num_ports; i++) begin
            sum = {1'b0, r_ptr} + (PW+1)'(i);
            if (sum >= (PW+1)'(num_ports))
                sum = sum - (PW+1)'(num_ports);
            idx = sum[PW-1:0];
            if (!w_found && req[idx]) begin
                w_found = 1'b1;
                w_sel   = idx;
            end
        end
    end

    // A grant seen while reset is asserted would be lost anyway, so hide it.
    assign w_go = w_found & rst_n;

    always_comb begin
        gnt        = '0;
        w_addr_sel = '0;
        w_wr_sel   = 1'b0;
        w_din_sel  = '0;
        if (w_go)
            gnt[w_sel] = 1'b1;
        for (int p = 0; p < num_ports; p++) begin
            if (w_sel == PW'(p)) begin
                w_addr_sel = addr[p*addr_size +: addr_size];
                w_wr_sel   = wr[p];
                w_din_sel  = data_in[p*word_size +: word_size];
            end
        end
    end

    assign w_in_range = ({1'b0, w_addr_sel} < MEM_LIM);
    assign w_mem_idx  = w_addr_sel[MW-1:0];
    assign w_rd_word  = w_in_range ? r_mem[w_mem_idx] : '0;
    assign w_ptr_nxt  = (w_sel == PW'(num_ports-1)) ? '0 : w_sel + PW'(1);

    always_ff @(posedge clk) begin
        if (w_go && w_wr_sel && w_in_range)
            r_mem[w_mem_idx] <= w_din_sel;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_ptr      <= '0;
            r_rd_valid <= '0;
            r_data_out <= '0;
        end else begin
            r_rd_valid <= '0;
            if (w_go) begin
                r_ptr <= w_ptr_nxt;
                if (!w_wr_sel) begin
                    r_rd_valid[w_sel] <= 1'b1;
                    for (int p = 0; p < num_ports; p++)
                        if (w_sel == PW'(p))
                            r_data_out[p*word_size +: word_size] <= w_rd_word;
                end
            end
        end
    end

    assign rd_valid = r_rd_valid;
    assign data_out = r_data_out;

endmodule

// File: tb/tb_ram_multiport_arb.sv
// Bench for ram_multiport_arb: directed vector table, reset/fairness sequences,
// and a randomized run against a queue-free behavioural model of the shared RAM.
module tb_ram_multiport_arb;

    localparam int AS = 10;
    localparam int WS = 8;
    localparam int MS = 1000;
    localparam int NP = 4;

    logic              clk = 1'b0;
    logic              rst_n;
    logic [NP-1:0]     req, wr, gnt, rd_valid;
    logic [NP*AS-1:0]  addr;
    logic [NP*WS-1:0]  data_in, data_out;

    int n_chk  = 0;
    int n_fail = 0;

    ram_multiport_arb #(.addr_size(AS), .word_size(WS), .memory_size(MS), .num_ports(NP)) dut (
        .clk(clk), .rst_n(rst_n), .req(req), .wr(wr), .addr(addr), .data_in(data_in),
        .gnt(gnt), .rd_valid(rd_valid), .data_out(data_out)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic [3:0]  req;
        logic [3:0]  wr;
        logic [39:0] addr;
        logic [31:0] din;
        logic [3:0]  gnt;
        logic [3:0]  rv;
        logic [31:0] dout;
    } vec_t;

    vec_t tbl[15];

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic vec_t v(input logic [3:0] rq, input logic [3:0] w,
                               input int a0, input int a1, input int a2, input int a3,
                               input logic [31:0] d, input logic [3:0] g,
                               input logic [3:0] rv, input logic [31:0] dout);
        vec_t r;
        r.req  = rq;  r.wr = w;
        r.addr = {10'(a3), 10'(a2), 10'(a1), 10'(a0)};
        r.din  = d;   r.gnt = g; r.rv = rv; r.dout = dout;
        return r;
    endfunction

    task automatic do_reset();
        rst_n = 1'b0; req = '0; wr = '0; addr = '0; data_in = '0;
        repeat (2) @(posedge clk);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
    endtask

    // Behavioural model state
    logic [7:0] m_mem [1024];
    bit         m_known [1024];
    logic [7:0] e_d [NP];
    bit         e_k [NP];
    logic [3:0] e_rv;
    int         last;
    bit         pend [NP];
    bit         pw [NP];
    int         pa [NP];
    logic [7:0] pd [NP];
    int         waitc [NP];

    // Round robin: the first requester after the previously granted port.
    function automatic int pick(input bit r [NP], input int lst);
        for (int k = 1; k <= NP; k++)
            if (r[(lst + k) % NP]) return (lst + k) % NP;
        return -1;
    endfunction

    initial begin
        // ---- reset state ----
        rst_n = 1'b0; req = '0; wr = '0; addr = '0; data_in = '0;
        #12;
        chk("reset rd_valid", 64'(rd_valid), 64'h0);
        chk("reset data_out", 64'(data_out), 64'h0);
        chk("reset gnt", 64'(gnt), 64'h0);
        @(negedge clk) rst_n = 1'b1;
        @(posedge clk); #1;
        chk("idle gnt", 64'(gnt), 64'h0);

        // ---- all ports requesting continuously: strict rotation ----
        req = 4'b1111; wr = 4'b0000;
        addr = {10'd5, 10'd5, 10'd5, 10'd5};
        for (int i = 0; i < 8; i++) begin
            @(negedge clk);
            chk($sformatf("rotation gnt %0d", i), 64'(gnt), 64'(4'b0001 << (i % 4)));
            @(posedge clk); #1;
            chk($sformatf("rotation rd_valid %0d", i), 64'(rd_valid), 64'(4'b0001 << (i % 4)));
        end

        // ---- directed vector table ----
        do_reset();
        tbl[0]  = v(4'b0001, 4'b0001,   5,    0,   0,    0, 32'h000000A5, 4'b0001, 4'b0000, 32'h00000000);
        tbl[1]  = v(4'b0001, 4'b0000,   5,    0,   0,    0, 32'h0,        4'b0001, 4'b0001, 32'h000000A5);
        tbl[2]  = v(4'b0001, 4'b0001,   7,    0,   0,    0, 32'h0000003C, 4'b0001, 4'b0000, 32'h000000A5);
        tbl[3]  = v(4'b1010, 4'b0000,   0,    7,   0,    7, 32'h0,        4'b0010, 4'b0010, 32'h00003CA5);
        tbl[4]  = v(4'b1000, 4'b0000,   0,    7,   0,    7, 32'h0,        4'b1000, 4'b1000, 32'h3C003CA5);
        tbl[5]  = v(4'b0000, 4'b0000,   0,    0,   0,    0, 32'h0,        4'b0000, 4'b0000, 32'h3C003CA5);
        tbl[6]  = v(4'b0100, 4'b0100,   0,    0,   9,    0, 32'h00110000, 4'b0100, 4'b0000, 32'h3C003CA5);
        tbl[7]  = v(4'b0001, 4'b0000,   9,    0,   0,    0, 32'h0,        4'b0001, 4'b0001, 32'h3C003C11);
        tbl[8]  = v(4'b0010, 4'b0000,   0, 1010,   0,    0, 32'h0,        4'b0010, 4'b0010, 32'h3C000011);
        tbl[9]  = v(4'b0010, 4'b0010,   0, 1010,   0,    0, 32'h0000EE00, 4'b0010, 4'b0000, 32'h3C000011);
        tbl[10] = v(4'b1000, 4'b0000,   0,    0,   0, 1010, 32'h0,        4'b1000, 4'b1000, 32'h00000011);
        tbl[11] = v(4'b0001, 4'b0001, 999,    0,   0,    0, 32'h0000005A, 4'b0001, 4'b0000, 32'h00000011);
        tbl[12] = v(4'b0100, 4'b0000,   0,    0, 999,    0, 32'h0,        4'b0100, 4'b0100, 32'h005A0011);
        tbl[13] = v(4'b1111, 4'b0000,   5,    5,   5,    5, 32'h0,        4'b1000, 4'b1000, 32'hA55A0011);
        tbl[14] = v(4'b1111, 4'b0000,   5,    5,   5,    5, 32'h0,        4'b0001, 4'b0001, 32'hA55A00A5);
        for (int i = 0; i < 15; i++) begin
            req = tbl[i].req; wr = tbl[i].wr; addr = tbl[i].addr; data_in = tbl[i].din;
            @(negedge clk);
            chk($sformatf("vec %0d gnt", i), 64'(gnt), 64'(tbl[i].gnt));
            @(posedge clk); #1;
            chk($sformatf("vec %0d rd_valid", i), 64'(rd_valid), 64'(tbl[i].rv));
            chk($sformatf("vec %0d data_out", i), 64'(data_out), 64'(tbl[i].dout));
        end

        // ---- reset asserted while a read grant is in flight ----
        req = 4'b0010; wr = 4'b0000; addr = {10'd5, 10'd5, 10'd5, 10'd5};
        @(negedge clk);
        chk("inflight gnt", 64'(gnt), 64'(4'b0010));
        #1 rst_n = 1'b0;
        #1;
        chk("async rd_valid", 64'(rd_valid), 64'h0);
        chk("async data_out", 64'(data_out), 64'h0);
        @(posedge clk); #1;
        chk("lost grant rd_valid", 64'(rd_valid), 64'h0);
        chk("lost grant data_out", 64'(data_out), 64'h0);
        req = 4'b0011;
        @(negedge clk) rst_n = 1'b1;
        #1;
        chk("post-reset gnt", 64'(gnt), 64'(4'b0001));
        @(posedge clk); #1;
        chk("post-reset rd_valid", 64'(rd_valid), 64'(4'b0001));
        chk("post-reset data_out0", 64'(data_out[7:0]), 64'hA5);

        // ---- randomized traffic against the model ----
        do_reset();
        last = NP - 1;
        e_rv = '0;
        for (int a = 0; a < 1024; a++) m_known[a] = 1'b0;
        for (int p = 0; p < NP; p++) begin
            e_d[p] = '0; e_k[p] = 1'b1; pend[p] = 1'b0; waitc[p] = 0;
        end
        for (int c = 0; c < 400; c++) begin
            int g;
            for (int p = 0; p < NP; p++) begin
                if (!pend[p] && $urandom_range(0, 2) != 0) begin
                    pend[p] = 1'b1;
                    pw[p] = 1'($urandom_range(0, 1));
                    pa[p] = ($urandom_range(0, 1) == 0) ? int'($urandom_range(0, 7))
                                                        : int'($urandom_range(995, 1003));
                    pd[p] = 8'($urandom);
                    waitc[p] = 0;
                end
                req[p] = pend[p];
                wr[p] = pw[p];
                addr[p*AS +: AS] = 10'(pa[p]);
                data_in[p*WS +: WS] = pd[p];
            end
            g = pick(pend, last);
            @(negedge clk);
            chk($sformatf("rand %0d gnt", c), 64'(gnt), (g < 0) ? 64'h0 : 64'(1) << g);
            @(posedge clk); #1;
            e_rv = '0;
            if (g >= 0) begin
                chk($sformatf("rand %0d wait port %0d", c, g), 64'(waitc[g] < NP), 64'h1);
                if (pw[g]) begin
                    if (pa[g] < MS) begin
                        m_mem[pa[g]] = pd[g];
                        m_known[pa[g]] = 1'b1;
                    end
                end else begin
                    e_rv[g] = 1'b1;
                    if (pa[g] >= MS) begin
                        e_d[g] = '0; e_k[g] = 1'b1;
                    end else begin
                        e_d[g] = m_mem[pa[g]]; e_k[g] = m_known[pa[g]];
                    end
                end
                pend[g] = 1'b0;
                last = g;
            end
            for (int p = 0; p < NP; p++)
                if (pend[p]) waitc[p]++;
            chk($sformatf("rand %0d rd_valid", c), 64'(rd_valid), 64'(e_rv));
            for (int p = 0; p < NP; p++)
                if (e_k[p])
                    chk($sformatf("rand %0d data_out%0d", c, p), 64'(data_out[p*WS +: WS]), 64'(e_d[p]));
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
        $finish;
    end

endmodule
